// File: rtl/ram_program_loader.sv
// ram_program_loader
//   Boot-time sequencer that copies program bytes from the external pins into
//   the CPU RAM through the shared 8-bit bus and the MAR/RAM strobes. It keeps
//   the CPU control sequencer idle (cpu_run=0) until the session completes.
//
// Optional feature macro: LOADER_READBACK_EN
//   When defined, a VERIFY state reads each written byte back over bus_in and
//   sets the sticky err flag if it differs from the byte that was written.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, finish            begin session (IDLE/DONE), end early (WAIT_BYTE)
//   byte_in/valid/ready      program byte handshake
//   bus_in                   shared bus value, readback only
//   bus_out, bus_oe          loader bus drive and ownership
//   n_load_addr/n_load_data  MAR strobes (active-low)
//   n_ram_write/n_ram_read   RAM strobes (active-low)
//   cpu_run, busy, done, err session status
//   addr                     address of the next byte to write
module ram_program_loader #(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              n_load_addr,
  output logic              n_load_data,
  output logic              n_ram_write,
  output logic              n_ram_read,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LADDR, S_LDATA, S_WRITE, S_VERIFY, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_BYTES - 1);

  state_t     state;
  logic [7:0] data_q;   // byte being written, held until the next accept
`ifdef LOADER_READBACK_EN
  logic       err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      data_q <= 8'h00;
`ifdef LOADER_READBACK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A byte presented together with start is not taken this cycle.
          if (start) begin
            state <= S_WAIT;
            addr  <= '0;
`ifdef LOADER_READBACK_EN
            err_q <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          // A byte beats finish; finish must be reasserted later.
          if (byte_valid) begin
            data_q <= byte_in;
            state  <= S_LADDR;
          end else if (finish) begin
            state <= S_DONE;
          end
        end
        S_LADDR: state <= S_LDATA;
        S_LDATA: state <= S_WRITE;
        S_WRITE: begin
`ifdef LOADER_READBACK_EN
          state <= S_VERIFY;
        end
        S_VERIFY: begin
          if (bus_in != data_q) err_q <= 1'b1;
`endif
          // Post-write: the last location ends the session without wrapping.
          if (addr == LAST) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode from state, byte latch and addr only.
  always_comb begin
    byte_ready  = (state == S_WAIT);
    bus_oe      = (state == S_LADDR) || (state == S_LDATA);
    bus_out     = 8'h00;
    if (state == S_LADDR) bus_out = 8'(addr);
    if (state == S_LDATA) bus_out = data_q;
    n_load_addr = (state != S_LADDR);
    n_load_data = (state != S_LDATA);
    n_ram_write = (state != S_WRITE);
    cpu_run     = (state == S_DONE);
    done        = (state == S_DONE);
    busy        = (state != S_IDLE) && (state != S_DONE);
`ifdef LOADER_READBACK_EN
    n_ram_read  = (state != S_VERIFY);
    err         = err_q;
`else
    n_ram_read  = 1'b1;
    err         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// tb_ram_program_loader
//   Randomized bench for ram_program_loader. A small MAR/RAM environment reacts
//   to the loader strobes; an array/counter model of the expected RAM image,
//   next address and error flag supplies every expected value.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, finish, byte_valid;
  logic [7:0] byte_in, bus_in, bus_out;
  logic       byte_ready, bus_oe, n_load_addr, n_load_data, n_ram_write, n_ram_read;
  logic       cpu_run, busy, done, err;
  logic [3:0] addr;

  ram_program_loader #(.RAM_BYTES(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .n_load_addr(n_load_addr), .n_load_data(n_load_data),
    .n_ram_write(n_ram_write), .n_ram_read(n_ram_read),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err), .addr(addr)
  );

  always #5 clk = ~clk;

`ifdef LOADER_READBACK_EN
  localparam int PER_BYTE = 5;
`else
  localparam int PER_BYTE = 4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAR/RAM environment driven by the loader strobes.
  logic [3:0] mar = 4'h0;
  logic [7:0] mdr = 8'h00;
  logic [7:0] ram [16];
  bit         force_bad = 1'b0;
  always @(posedge clk) begin
    if (!n_load_addr) mar <= bus_out[3:0];
    if (!n_load_data) mdr <= bus_out;
    if (!n_ram_write) ram[mar] <= mdr;
  end
  always_comb begin
    bus_in = 8'h00;
    if (!n_ram_read) bus_in = force_bad ? 8'h00 : ram[mar];
  end

  // Reference model: expected RAM image, next address, error flag.
  logic [7:0] exp_ram [16];
  int         exp_addr = 0;
  bit         exp_err  = 1'b0;
  int         t0 = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus_clash", {31'b0, bus_oe & ~n_ram_read}, 0);
      chk("ready_busy", {31'b0, byte_ready & ~busy}, 0);
`ifndef LOADER_READBACK_EN
      chk("rd_tied", {31'b0, n_ram_read}, 1);
`endif
    end
  end

  task automatic chk_reset_vals();
    chk("rst_bus_out", bus_out, 0);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_strobes", {n_load_addr, n_load_data, n_ram_write, n_ram_read}, 4'hF);
    chk("rst_status", {byte_ready, cpu_run, busy, done, err}, 0);
    chk("rst_addr", addr, 0);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 16; i++) chk($sformatf("ram[%0d]", i), ram[i], exp_ram[i]);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    exp_addr = 0;
    exp_err  = 1'b0;
    chk("start_ready", byte_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_addr", addr, 0);
    chk("start_run_done", {cpu_run, done}, 0);
    chk("start_err", err, 0);
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("fin_done_run", {done, cpu_run}, 2'b11);
    chk("fin_busy_rdy", {busy, byte_ready}, 0);
    chk("fin_addr", addr, exp_addr);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_fin,
                           input bit pulse_start, input bit bad);
    int n;
    bit last;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b; byte_valid = 1'b1; finish = with_fin; n = 0;
    while (!byte_ready && n < 40) begin @(negedge clk); n++; end
    if (!byte_ready) begin
      chk("accept_timeout", 0, 1);
      byte_valid = 1'b0; finish = 1'b0;
      return;
    end
    force_bad = bad;
    @(negedge clk); finish = 1'b0;
    chk("laddr_strobe", n_load_addr, 0);
    chk("laddr_bus", {bus_oe, bus_out}, {1'b1, 8'(exp_addr)});
    chk("laddr_done", done, 0);
    @(negedge clk);
    chk("ldata_strobe", n_load_data, 0);
    chk("ldata_bus", {bus_oe, bus_out}, {1'b1, b});
    if (pulse_start) start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("write_strobe", {n_ram_write, bus_oe, busy}, 3'b001);
`ifdef LOADER_READBACK_EN
    @(negedge clk);
    chk("verify_strobe", {n_ram_read, bus_oe}, 0);
    if (bad && b != 8'h00) exp_err = 1'b1;
`endif
    @(negedge clk);
    force_bad = 1'b0;
    byte_valid = 1'b0;
    exp_ram[exp_addr] = b;
    last = (exp_addr == 15);
    if (!last) exp_addr++;
    if (last) chk("post_done", {done, cpu_run, byte_ready}, 3'b110);
    else      chk("post_ready", {byte_ready, done}, 2'b10);
    chk("post_addr", addr, exp_addr);
    chk("post_err", err, exp_err);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k, fi, si;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'($urandom);
      exp_ram[i] = ram[i];
    end
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_run", {cpu_run, busy}, 0);

    // Full back-to-back load 0x10..0x1F.
    do_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0, 1'b0, 1'b0, 1'b0);
    chk("full_cycles", cyc - t0, 16 * PER_BYTE);
    chk("full_addr", addr, 15);
    check_ram();
    @(negedge clk);
    chk("done_holds", {done, cpu_run, addr}, {2'b11, 4'hF});

    // Early finish after three bytes.
    do_start();
    send_byte(8'hAA, 0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBB, 1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hCC, 2, 1'b0, 1'b0, 1'b0);
    do_finish();
    chk("fin3_addr", addr, 3);
    check_ram();

    // byte_valid with finish, and start during LOAD_DATA.
    do_start();
    send_byte(8'h3C, 0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hC3, 0, 1'b0, 1'b1, 1'b0);
    chk("start_ignored_addr", addr, 2);
    do_finish();
    check_ram();

`ifdef LOADER_READBACK_EN
    // Readback mismatch sets a sticky err.
    do_start();
    send_byte(8'h5A, 0, 1'b0, 1'b0, 1'b1);
    chk("rb_err_set", err, 1);
    send_byte(8'h66, 1, 1'b0, 1'b0, 1'b0);
    do_finish();
    chk("rb_err_sticky", err, 1);
    do_start();
    do_finish();
    check_ram();
`endif

    // Randomized sessions.
    for (int s = 0; s < 5; s++) begin
      k  = $urandom_range(1, 16);
      fi = $urandom_range(0, k - 1);
      si = $urandom_range(0, k - 1);
      do_start();
      for (int i = 0; i < k; i++)
        send_byte(8'($urandom), $urandom_range(0, 3), i == fi, i == si, 1'b0);
      if (k < 16) do_finish();
      else chk("rand_full_done", done, 1);
      check_ram();
    end

    // Reset in LOAD_DATA abandons the byte.
    do_start();
    byte_in = 8'h77; byte_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("pre_rst_ldata", n_load_data, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {cpu_run, busy, done}, 0);
    check_ram();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
